// File: rtl/debug_host_bridge_if.sv
// Host-link and debug-register-bus signals of debug_host_bridge.
// The master modport is the bridge; the slave modport is the host front-end plus the core.
interface debug_host_bridge_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [2:0] DEBUG_REG_ADDR;
    logic [7:0] DEBUG_DOUT;
    logic [7:0] DEBUG_DIN;
    logic       DEBUG_RDN;
    logic       DEBUG_WRN;
    logic       BUSY;

    modport master (
        input  RX_DATA, RX_VALID, TX_READY, DEBUG_DIN,
        output RX_READY, TX_DATA, TX_VALID, DEBUG_REG_ADDR, DEBUG_DOUT,
               DEBUG_RDN, DEBUG_WRN, BUSY
    );

    modport slave (
        output RX_DATA, RX_VALID, TX_READY, DEBUG_DIN,
        input  RX_READY, TX_DATA, TX_VALID, DEBUG_REG_ADDR, DEBUG_DOUT,
               DEBUG_RDN, DEBUG_WRN, BUSY
    );
endinterface

// File: rtl/debug_host_bridge.sv
// Byte-stream master for the core's 8-bit debug register port (initiator side).
// Optional build macro DEBUG_BRIDGE_WRITE_ACK_EN: send 0xA5 to the host after each write command.
module debug_host_bridge #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    debug_host_bridge_if.master   bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        HOLD     = 3'd4,
        SEND     = 3'd5
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] rem, rem_n;
    logic       is_write, is_write_n;
    logic [2:0] addr, addr_n;
    logic [7:0] dout, dout_n;
    logic [7:0] tx_data, tx_data_n;
    logic       tx_valid, rx_ready, rdn, wrn, busy;
    logic       rx_fire, tx_fire;

    // Both links use valid/ready: a byte moves on a rising CLK edge where valid and
    // ready are both high; the sender holds data and valid steady until that edge.
    assign rx_fire = rx_ready & bus.RX_VALID;
    assign tx_fire = tx_valid & bus.TX_READY;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rem_n      = rem;
        is_write_n = is_write;
        addr_n     = addr;
        dout_n     = dout;
        tx_data_n  = tx_data;
        case (state)
            IDLE: if (rx_fire) begin
                is_write_n = bus.RX_DATA[7];
                rem_n      = bus.RX_DATA[6:3];
                addr_n     = bus.RX_DATA[2:0];
                state_n    = bus.RX_DATA[7] ? GET_DATA : SETUP;
            end
            GET_DATA: if (rx_fire) begin
                dout_n  = bus.RX_DATA;
                state_n = SETUP;
            end
            SETUP: begin
                cnt_n   = STROBE_LOAD;
                state_n = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (!is_write) tx_data_n = bus.DEBUG_DIN;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (!is_write) begin
                    state_n = SEND;
                end else if (rem != 4'd0) begin
                    rem_n   = rem - 4'd1;
                    state_n = GET_DATA;
                end else begin
`ifdef DEBUG_BRIDGE_WRITE_ACK_EN
                    tx_data_n = 8'hA5;
                    state_n   = SEND;
`else
                    state_n   = IDLE;
`endif
                end
            end
            SEND: if (tx_fire) begin
                if (!is_write && rem != 4'd0) begin
                    rem_n   = rem - 4'd1;
                    state_n = SETUP;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change exactly on state entry.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rem      <= 4'd0;
            is_write <= 1'b0;
            addr     <= 3'd0;
            dout     <= 8'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            rx_ready <= 1'b0;
            rdn      <= 1'b1;
            wrn      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            is_write <= is_write_n;
            addr     <= addr_n;
            dout     <= dout_n;
            tx_data  <= tx_data_n;
            tx_valid <= (state_n == SEND);
            rx_ready <= (state_n == IDLE) || (state_n == GET_DATA);
            rdn      <= !((state_n == STROBE) && !is_write_n);
            wrn      <= !((state_n == STROBE) && is_write_n);
            busy     <= (state_n != IDLE);
        end
    end

    assign bus.RX_READY       = rx_ready;
    assign bus.TX_DATA        = tx_data;
    assign bus.TX_VALID       = tx_valid;
    assign bus.DEBUG_REG_ADDR = addr;
    assign bus.DEBUG_DOUT     = dout;
    assign bus.DEBUG_RDN      = rdn;
    assign bus.DEBUG_WRN      = wrn;
    assign bus.BUSY           = busy;
    assign dbg_state          = state;
endmodule

// File: doc/debug_host_bridge.md
# debug_host_bridge

Byte-stream master for the core's 8-bit debugger register port: receives command and data bytes from a host link (UART receiver or JTAG shim), runs read/write strobe cycles on the `DEBUG_*` register bus, and returns read data as bytes. It sits outside the core, between the host serial front-end and the core's debug pins. It is the initiator side of the debug port protocol.

## Interface

Parameters:
- `STROBE_CYCLES`, default 2: cycles `DEBUG_RDN` or `DEBUG_WRN` is held low per transfer; legal range 1–15.

Ports. One clock; reset is asynchronous and active-low.
- `CLK` in 1: system clock, rising edge.
- `RESETN` in 1: asynchronous active-low reset.
- `RX_DATA` in 8: host byte.
- `RX_VALID` in 1: `RX_DATA` valid.
- `RX_READY` out 1: bridge accepts a byte. Transfer occurs when `RX_VALID & RX_READY`.
- `TX_DATA` out 8: byte to host.
- `TX_VALID` out 1: `TX_DATA` valid.
- `TX_READY` in 1: host accepts. Transfer occurs when `TX_VALID & TX_READY`.
- `DEBUG_REG_ADDR` out 3: debug register address, to the core's `DEBUG_REG_ADDR`.
- `DEBUG_DOUT` out 8: write data, to the core's `DEBUG_DIN`.
- `DEBUG_DIN` in 8: read data, from the core's `DEBUG_DOUT`.
- `DEBUG_RDN` out 1: active-low read strobe.
- `DEBUG_WRN` out 1: active-low write strobe.
- `BUSY` out 1: high in any state other than IDLE.

## Operation

Command byte fields:
- `[7]` W: 1 = write, 0 = read.
- `[6:3]` N-1: the transfer count N is 1–16.
- `[2:0]` register address.

All transfers of one command use the same address. The core's data register auto-increments, so a burst streams memory.

FSM states: IDLE, GET_DATA, SETUP, STROBE, HOLD, SEND.
- IDLE: `RX_READY`=1. On accepting a command, latch W, count and address.
  - W=1 → GET_DATA.
  - W=0 → SETUP.
- GET_DATA: `RX_READY`=1. On accepting a byte, latch it into `DEBUG_DOUT` → SETUP.
- SETUP: 1 cycle with address (and data) stable and both strobes high → STROBE.
- STROBE: the selected strobe is low for exactly `STROBE_CYCLES` cycles (4-bit down-counter). On a read, `DEBUG_DIN` is captured into `TX_DATA` on the last strobe cycle → HOLD.
- HOLD: 1 cycle, strobes high, address and data held. Then:
  - Read → SEND.
  - Write with transfers remaining → GET_DATA, decrement the remaining count.
  - Write, last transfer → IDLE, or SEND when the ACK feature is enabled.
- SEND: `TX_VALID`=1 and `TX_DATA` stable until `TX_READY`. On the handshake:
  - Read with transfers remaining → SETUP, decrement the remaining count.
  - Otherwise → IDLE.
- Only one strobe is ever low, and never in SETUP or HOLD.
- `RX_READY` is 0 outside IDLE and GET_DATA. Host bytes wait; none are dropped.
- The remaining-count register is 4 bits and is checked for zero before decrementing, so it never wraps.
- There is no abort. A burst completes once started.

## Timing

Reset values (asynchronous assertion, synchronous deassertion to IDLE):
- `DEBUG_RDN`=1, `DEBUG_WRN`=1.
- `DEBUG_REG_ADDR`=0, `DEBUG_DOUT`=0.
- `TX_DATA`=0, `TX_VALID`=0.
- `BUSY`=0.
- `RX_READY`=0 while `RESETN` is low; 1 from the first clock after release.

Read cycle timing (S = `STROBE_CYCLES`; cycle 0 = command handshake):
- SETUP at cycle 1.
- `DEBUG_RDN` low during cycles 2..1+S.
- HOLD at cycle 2+S.
- `TX_VALID` rises at cycle 3+S.

Write timing (cycle 0 = data-byte handshake):
- `DEBUG_WRN` low during cycles 2..1+S.
- `RX_READY` rises again at cycle 3+S.

Read burst: the next SETUP follows the `TX_READY` handshake by 1 cycle.

Reset asserted mid-strobe: strobes return high combinationally from reset, with no glitch low. Partial command state is discarded.

All outputs are registered.

## Configuration

- `DEBUG_BRIDGE_WRITE_ACK_EN` defined: after the last transfer of a write command, SEND emits `TX_DATA`=0xA5. The host then has an explicit completion marker per write command.
- Not defined: write commands produce no TX traffic, and HOLD goes directly to IDLE. Read behaviour is identical in both builds.

## Test plan

- Reset: hold `RESETN` low with random `RX_VALID` → strobes 1, `TX_VALID`=0, `RX_READY`=0, `BUSY`=0; after release `RX_READY`=1 within 1 cycle.
- Single read: S=2; RX 0x03, core drives `DEBUG_DIN`=0x5A → `DEBUG_REG_ADDR`=3, `DEBUG_RDN` low exactly cycles 2–3, `TX_VALID` at cycle 5 with `TX_DATA`=0x5A.
- Write burst: RX 0x8A, 0x11, 0x22 → two `DEBUG_WRN` pulses at addr 2 with `DEBUG_DOUT` 0x11 then 0x22. With ACK_EN, exactly one 0xA5 follows; without, no `TX_VALID`.
- Read burst: RX 0x1C, core returns 0x01..0x04 on successive reads → four `DEBUG_RDN` pulses at addr 4 and TX 0x01, 0x02, 0x03, 0x04 in order.
- Backpressure: single read with `TX_READY` low for 10 cycles → `TX_VALID` and `TX_DATA` stable, `RX_READY`=0, no further strobe; IDLE 1 cycle after the handshake.
- Reset mid-operation: deassert `RESETN` while `DEBUG_WRN` is low → `DEBUG_WRN`=1 the same cycle; after release, RX 0x03 performs a clean single read.
